// File: rtl/mem_read_sched.sv
// rtl/mem_read_sched.sv - per-BX read scheduler for the 12-port memory readout mux
//
// Once per bunch crossing, snapshots every memory's entry count and emits one
// header slot. It then reads each non-empty memory in turn, lowest port first.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   start    one-cycle pulse marking a new BX (also restarts a readout in progress)
//   bx_in    BX number, sampled on start
//   nent     packed entry counts; port i at [i*(ADDR_W+1) +: ADDR_W+1]
//   rd_addr  shared memory read address
//   rd_en    one-hot memory read enable
//   sel_out  mux select, delayed RD_LAT cycles to line up with read data
//   bx_out   latched BX, aligned with sel_out
//   busy     high whenever the scheduler is not idle
//   done     one-cycle pulse when a BX readout completes
module mem_read_sched #(
  parameter int NMEM   = 12,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [2:0]                 bx_in,
  input  logic [NMEM*(ADDR_W+1)-1:0] nent,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [NMEM-1:0]            rd_en,
  output logic [3:0]                 sel_out,
  output logic [2:0]                 bx_out,
  output logic                       busy,
  output logic                       done
);

  localparam int            CW   = ADDR_W + 1;
  localparam logic [CW-1:0] CMAX = CW'(1 << ADDR_W);
  localparam logic [3:0]    SEL_HDR = 4'd15;

  typedef enum logic [2:0] {IDLE, HEADER, SCAN, READ, DONE} state_t;

  state_t            state, state_n;
  logic [3:0]        cur, cur_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [CW-1:0]     snap [NMEM];
  logic [NMEM-1:0]   served;
  logic [2:0]        bx_q;
  logic [3:0]        sel_q;

  logic [NMEM-1:0]   rd_en_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [3:0]        sel_n;
  logic              done_n;
  logic              take;
  logic              mark;

  logic              hit;
  logic [3:0]        pick;
  logic              last;

  logic [3:0]        sel_pipe [RD_LAT];
  logic [2:0]        bx_pipe  [RD_LAT];

  // Ports 9..11 skip select code 10; 14 is unused and 15 marks the header.
  function automatic logic [3:0] enc(input logic [3:0] p);
    return (p < 4'd9) ? p + 4'd1 : p + 4'd2;
  endfunction

  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] c);
    return (c > CMAX) ? CMAX : c;
  endfunction

  // Lowest-numbered port that still has data and has not been read this BX.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int i = NMEM - 1; i >= 0; i--) begin
      if (snap[i] != '0 && !served[i]) begin
        hit  = 1'b1;
        pick = 4'(i);
      end
    end
  end

  // Counter runs one bit narrower than the count, so a full memory ends at
  // all-ones; the wider compare catches that without the counter wrapping.
  assign last = (({1'b0, cnt} + CW'(1)) == snap[cur]);

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    cnt_n     = cnt;
    rd_en_n   = '0;
    rd_addr_n = '0;
    sel_n     = '0;
    done_n    = 1'b0;
    take      = 1'b0;
    mark      = 1'b0;

    case (state)
      IDLE: ;
      HEADER: state_n = SCAN;
      SCAN: begin
        if (hit) begin
          state_n = READ;
          cur_n   = pick;
          cnt_n   = '0;
          rd_en_n = NMEM'(1) << pick;
          sel_n   = enc(pick);
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      READ: begin
        if (last) begin
          mark    = 1'b1;
          state_n = SCAN;
        end else begin
          cnt_n     = cnt + 1'b1;
          rd_en_n   = NMEM'(1) << cur;
          rd_addr_n = cnt + 1'b1;
          sel_n     = enc(cur);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A new BX overrides whatever is in progress; the aborted BX gets no done.
    if (start) begin
      state_n   = HEADER;
      take      = 1'b1;
      mark      = 1'b0;
      rd_en_n   = '0;
      rd_addr_n = '0;
      sel_n     = SEL_HDR;
      done_n    = 1'b0;
    end
  end

  // Outputs are registered alongside the state so they change with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cur     <= '0;
      cnt     <= '0;
      served  <= '0;
      bx_q    <= '0;
      sel_q   <= '0;
      rd_en   <= '0;
      rd_addr <= '0;
      done    <= 1'b0;
      for (int i = 0; i < NMEM; i++) snap[i] <= '0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      cnt     <= cnt_n;
      sel_q   <= sel_n;
      rd_en   <= rd_en_n;
      rd_addr <= rd_addr_n;
      done    <= done_n;
      if (take) begin
        bx_q   <= bx_in;
        served <= '0;
        for (int i = 0; i < NMEM; i++) snap[i] <= clamp(nent[i*CW +: CW]);
      end else if (mark) begin
        served[cur] <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  // Select and BX trail the read strobe by the memory latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        sel_pipe[i] <= '0;
        bx_pipe[i]  <= '0;
      end
    end else begin
      sel_pipe[0] <= sel_q;
      bx_pipe[0]  <= bx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        sel_pipe[i] <= sel_pipe[i-1];
        bx_pipe[i]  <= bx_pipe[i-1];
      end
    end
  end

  assign sel_out = sel_pipe[RD_LAT-1];
  assign bx_out  = bx_pipe[RD_LAT-1];

endmodule

// File: tb/tb_mem_read_sched.sv
// tb/tb_mem_read_sched.sv - scoreboard bench for mem_read_sched
module tb_mem_read_sched;

  localparam int NMEM = 12;
  localparam int AW   = 6;
  localparam int CW   = AW + 1;
  localparam int ENC [NMEM] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 13};

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              start3 = 1'b0;
  logic [2:0]        bx_in = '0;
  logic [CW-1:0]     cnt_v [NMEM];
  logic [NMEM*CW-1:0] nent;

  logic [AW-1:0]     rd_addr, rd_addr3;
  logic [NMEM-1:0]   rd_en, rd_en3;
  logic [3:0]        sel_out, sel_out3;
  logic [2:0]        bx_out, bx_out3;
  logic              busy, busy3, done, done3;

  always_comb begin
    nent = '0;
    for (int i = 0; i < NMEM; i++) nent[i*CW +: CW] = cnt_v[i];
  end

  mem_read_sched #(.NMEM(NMEM), .ADDR_W(AW), .RD_LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bx_in(bx_in), .nent(nent),
    .rd_addr(rd_addr), .rd_en(rd_en), .sel_out(sel_out), .bx_out(bx_out),
    .busy(busy), .done(done));

  mem_read_sched #(.NMEM(NMEM), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .bx_in(bx_in), .nent(nent),
    .rd_addr(rd_addr3), .rd_en(rd_en3), .sel_out(sel_out3), .bx_out(bx_out3),
    .busy(busy3), .done(done3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; int port; int addr; } rd_t;
  typedef struct { int cyc; int sel; int bx; } sel_t;
  rd_t  q_rd  [$];
  sel_t q_sel [$];
  int   q_done[$];
  rd_t  e_rd;
  sel_t e_sel;
  int   e_done;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (rd_en != '0) begin
        if (q_rd.size() == 0) check("rd_unexpected", int'(rd_en), 0);
        else begin
          e_rd = q_rd.pop_front();
          check("rd_cycle", cyc, e_rd.cyc);
          check("rd_en", int'(rd_en), 1 << e_rd.port);
          check("rd_addr", int'(rd_addr), e_rd.addr);
        end
      end
      if (sel_out != '0) begin
        if (q_sel.size() == 0) check("sel_unexpected", int'(sel_out), 0);
        else begin
          e_sel = q_sel.pop_front();
          check("sel_cycle", cyc, e_sel.cyc);
          check("sel_out", int'(sel_out), e_sel.sel);
          check("bx_out", int'(bx_out), e_sel.bx);
        end
      end
      if (done) begin
        if (q_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e_done = q_done.pop_front();
          check("done_cycle", cyc, e_done);
        end
      end
    end
  end

  // Expected events for an uninterrupted BX whose header is in cycle base+1.
  task automatic gen(input int base, input int bx);
    int t;
    int c;
    q_sel.push_back('{base + 2, 15, bx});
    t = base + 2;
    for (int p = 0; p < NMEM; p++) begin
      c = (int'(cnt_v[p]) > 64) ? 64 : int'(cnt_v[p]);
      if (c > 0) begin
        for (int a = 0; a < c; a++) begin
          q_rd.push_back('{t + 1 + a, p, a});
          q_sel.push_back('{t + 2 + a, ENC[p], bx});
        end
        t = t + 1 + c;
      end
    end
    q_done.push_back(t + 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int base);
    step();
    base  = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && !(q_rd.size() == 0 && q_sel.size() == 0 &&
                           q_done.size() == 0 && !busy)) begin
      step();
      i++;
    end
    check("drain_in_budget", int'(i < budget), 1);
    repeat (4) step();
    q_rd.delete();
    q_sel.delete();
    q_done.delete();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NMEM; i++) cnt_v[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    check("reset_sel_out", int'(sel_out), 0);
    check("reset_bx_out", int'(bx_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // All counts zero: header only, busy for cycles 1..3.
    bx_in = 3'd2;
    pulse_start(b);
    gen(b, 2);
    for (int k = 1; k <= 4; k++) begin
      check("busy_zero", int'(busy), int'(k <= 3));
      step();
    end
    wait_idle(50);

    // Restart coincident with DONE: done still fires, HEADER follows directly.
    bx_in = 3'd1;
    pulse_start(b);
    gen(b, 1);
    step();
    step();
    cnt_v[3] = 7'd1;
    bx_in = 3'd4;
    start = 1'b1;
    gen(b + 3, 4);
    step();
    start = 1'b0;
    check("restart_from_done_busy", int'(busy), 1);
    wait_idle(50);
    clear_counts();

    // Port 0 = 3, port 9 = 2; nent scribbled after the snapshot.
    cnt_v[0] = 7'd3;
    cnt_v[9] = 7'd2;
    bx_in = 3'd5;
    pulse_start(b);
    gen(b, 5);
    for (int i = 0; i < NMEM; i++) cnt_v[i] = 7'd5;
    bx_in = 3'd0;
    wait_idle(50);
    clear_counts();

    // Full memories: 64 exactly and 127 clamped to 64.
    cnt_v[10] = 7'd64;
    cnt_v[11] = 7'd127;
    bx_in = 3'd7;
    pulse_start(b);
    gen(b, 7);
    wait_idle(300);
    clear_counts();

    // Restart in the middle of port 0's reads.
    cnt_v[0] = 7'd3;
    cnt_v[9] = 7'd2;
    bx_in = 3'd6;
    pulse_start(b);
    q_rd.push_back('{b + 3, 0, 0});
    q_rd.push_back('{b + 4, 0, 1});
    q_sel.push_back('{b + 2, 15, 6});
    q_sel.push_back('{b + 4, 1, 6});
    q_sel.push_back('{b + 5, 1, 6});
    step();
    step();
    step();
    clear_counts();
    cnt_v[1] = 7'd2;
    bx_in = 3'd3;
    start = 1'b1;
    gen(b + 4, 3);
    step();
    start = 1'b0;
    check("abort_rd_en", int'(rd_en), 0);
    wait_idle(50);
    clear_counts();

    // RD_LAT = 3 instance, port 2 with one entry.
    cnt_v[2] = 7'd1;
    bx_in = 3'd2;
    step();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("lat3_rd_en", int'(rd_en3), (k == 3) ? 4 : 0);
      check("lat3_sel_out", int'(sel_out3), (k == 4) ? 15 : ((k == 6) ? 3 : 0));
      check("lat3_done", int'(done3), int'(k == 5));
      if (k == 6) check("lat3_bx_out", int'(bx_out3), 2);
      step();
    end
    clear_counts();

    // Asynchronous reset while port 0 is being read.
    cnt_v[0] = 7'd3;
    bx_in = 3'd5;
    pulse_start(b);
    q_sel.push_back('{b + 2, 15, 5});
    step();
    step();
    check("pre_reset_rd_en", int'(rd_en), 1);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rd_en", int'(rd_en), 0);
    check("async_rd_addr", int'(rd_addr), 0);
    check("async_sel_out", int'(sel_out), 0);
    check("async_bx_out", int'(bx_out), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("pre_reset_header_seen", q_sel.size(), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    q_rd.delete();
    q_sel.delete();
    q_done.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("post_reset_idle", int'(busy), 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_read_sched.md
Name: mem_read_sched

Overview:
- Read scheduler that sequences the 12-port memory readout mux once per bunch crossing (BX).
- On each BX start it snapshots every memory's entry count and issues one header slot. It then walks the non-empty memories in fixed priority order (port 0 first), driving read address and enable for each memory.
- It drives the mux select, delayed to align with memory read data.
- Its outputs feed the mux `sel`/`BX` inputs and the memories' read ports directly.

Parameters:
- NMEM, 12, number of memories; the select encoding below is fixed for 12.
- ADDR_W, 6, memory read address width.
- RD_LAT, 1, memory read latency in clocks (1..4); delay applied to sel_out/bx_out.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse marking a new BX
- bx_in  input  3  BX number, sampled on start
- nent  input  NMEM*(ADDR_W+1)  packed entry counts; port i occupies bits [i*(ADDR_W+1) +: ADDR_W+1]
- rd_addr  output  ADDR_W  shared read address
- rd_en  output  NMEM  one-hot read enable
- sel_out  output  4  binary mux select, aligned with read data
- bx_out  output  3  latched BX, aligned with sel_out
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a BX readout completes

Behaviour:
- Reset (async, reset_n=0): state IDLE. rd_addr=0, rd_en=0, sel_out=0, bx_out=0, busy=0, done=0. Snapshot registers, served mask and delay pipeline are all cleared.
- Select encoding (internal sel):
  - idle = 0
  - port i = i+1 for i=0..8
  - port 9 = 11, port 10 = 12, port 11 = 13
  - header = 15
  - 10 and 14 are never generated.
- Cycle numbering: cycle k = register values after clock edge k.
- State machine:
  - IDLE: sel=0. On start: latch bx_in and all nent counts, clamping each count to 2^ADDR_W; clear the served mask; go to HEADER.
  - HEADER: one cycle, sel=15, rd_en=0; go to SCAN.
  - SCAN: one cycle, sel=0, rd_en=0. A priority encoder finds the lowest port p with nonzero snapshot count that is not yet served.
    - If found: set cur=p, rd_addr counter=0; go to READ.
    - Else: go to DONE.
  - READ: each cycle rd_en[cur]=1, rd_addr=counter, sel=enc(cur), counter increments. After the cycle with counter=count[cur]-1, mark cur served and go to SCAN.
  - DONE: one cycle, done=1, sel=0; go to IDLE.
- Delay pipeline: rd_en and rd_addr are registered outputs of the state logic. sel_out and bx_out are internal sel/BX delayed by exactly RD_LAT further cycles, so sel_out for a read equals the cycle its data reaches the mux. Header ordering is preserved through the same pipeline.
- start in any non-IDLE state restarts the readout:
  - The current read stops; rd_en=0 from the next cycle.
  - A new snapshot is taken; HEADER is entered the next cycle.
  - done is not pulsed for the aborted BX.
  - Reads already in the delay pipeline still drain to sel_out.
- start coincident with DONE: DONE still pulses done, and HEADER follows directly without passing through IDLE.
- nent changes after the snapshot are ignored until the next start.
- All counts zero: HEADER, SCAN, DONE; only the header slot appears on sel_out.
- Count = 2^ADDR_W: rd_addr reaches all-ones, and the counter must not wrap before the port is marked served.
- Per-BX cycle cost: 3 + sum over non-empty ports of (1 + count).

Test Plan:
- Reset mid-READ (reset_n low for 1 cycle while rd_en[0]=1) -> all outputs 0 asynchronously; IDLE after release; no done.
- All counts 0, start at edge 0, RD_LAT=1 -> sel_out=15 at cycle 2 only; done=1 at cycle 3; busy high cycles 1-3.
- Port 0 count 3, port 9 count 2, bx_in=5, RD_LAT=1, start at edge 0 -> expected timing:
  - rd_en[0] with addr 0,1,2 at cycles 3-5.
  - rd_en[9] with addr 0,1 at cycles 7-8.
  - sel_out=15 at cycle 2, =1 at cycles 4-6, =11 at cycles 8-9, 0 elsewhere.
  - bx_out=5 throughout; done at cycle 10.
- Port 11 count 64 (input 127 also clamps to 64), ADDR_W=6 -> 64 reads, rd_addr 0..63; sel_out=13 for 64 cycles.
- start re-pulsed at cycle 4 of the port 0/9 scenario -> rd_en=0 at cycle 5; HEADER at cycle 5; new snapshot used; only one done in total.
- RD_LAT=3, port 2 count 1 -> rd_en[2] at cycle 3; sel_out=3 at cycle 6; header sel_out=15 at cycle 4.
